sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised FIFO; the successor to the existing two-clock FIFO for same-domain buffering.
- Stores DATA_WIDTH-bit words in a FIFO_DEPTH-entry array.
- Correct wrap-around pointers and an occupancy count.
- Programmable almost-full/almost-empty thresholds.
- Sticky overflow/underflow error flags.
- Selectable standard (registered read) or first-word-fall-through (FWFT) output mode.

Parameters:
- DATA_WIDTH, 8, word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries; power of two, >=2.
- PNTR_WIDTH, $clog2(FIFO_DEPTH), read/write pointer width (derived; do not override).
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = standard mode, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- clr  in  1  synchronous flush, active-high: empties FIFO and clears error flags.
- we  in  1  write request.
- din  in  DATA_WIDTH  write data.
- re  in  1  read request (FWFT: pop/acknowledge of dout).
- dout  out  DATA_WIDTH  read data.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  PNTR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst==0 at posedge):
  - w_ptr=0, r_ptr=0, count=0.
  - dout=0, overflow=0, underflow=0.
  - Flags follow count: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Memory contents are not cleared.
  - Reset overrides clr, we and re; a transfer in flight is discarded.
- clr==1 (rst high): same as reset, except memory is untouched and dout holds its value. clr overrides we/re.
- Accept rules, evaluated from state before the edge:
  - rd_ok = re && !empty.
  - wr_ok = we && (!full || rd_ok).
  - A full FIFO with simultaneous we&re accepts both; count is unchanged.
  - An empty FIFO with simultaneous we&re accepts the write only.
  - The read is rejected and underflow is set.
- wr_ok: mem[w_ptr] <= din; w_ptr <= w_ptr+1, wrapping modulo FIFO_DEPTH.
- rd_ok: r_ptr <= r_ptr+1, wrapping.
- count update:
  - +1 if wr_ok && !rd_ok.
  - -1 if rd_ok && !wr_ok.
  - Otherwise unchanged.
  - Never leaves 0..FIFO_DEPTH.
- Errors:
  - overflow <= 1 when we && !wr_ok.
  - underflow <= 1 when re && !rd_ok.
  - Both hold until rst or clr.
  - Rejected operations change no other state.
- Flags are combinational decodes of the registered count, so they change on the same edge as count.
- FWFT=0 (standard mode):
  - On rd_ok, dout <= mem[r_ptr]. Data is valid the cycle after the re edge (1-cycle read latency).
  - dout holds its last value otherwise, including when empty.
- FWFT=1:
  - dout = mem[r_ptr] combinationally, valid whenever empty==0.
  - A word written at edge N appears on dout after edge N once empty has fallen.
  - re consumes the word shown on dout.
  - dout is don't-care when empty.
- Write-to-read: a word written at edge N is readable from edge N+1 on. No same-cycle bypass.
- The design is synthesisable: a single always_ff block for state, with no latches.

Test Plan:
1. Reset/flags:
   - Hold rst=0 for 2 clocks, then release.
   - Required: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0.
2. Fill and drain (FWFT=0, depth 8):
   - Write 0x10..0x17 on 8 consecutive clocks, then write 0xAA with FIFO full.
   - Required: full=1, count=8, almost_full set at count=6, overflow=1; 0xAA is discarded.
   - Then read 8 times.
   - Required: dout = 0x10..0x17 in order, each one cycle after its re; empty=1 after the 8th read.
3. Wrap-around and simultaneous access:
   - Preload 5 words, then assert we&re together for 20 clocks with din incrementing from 0x40.
   - Required: count stays 5 throughout, pointers wrap cleanly, and the output sequence is continuous with no loss or duplication.
4. Full with simultaneous read/write:
   - With count=8, assert we=1 (din=0x55) and re=1 together.
   - Required: both are accepted, count stays 8, overflow stays 0, and 0x55 emerges 8 reads later.
5. Empty boundary:
   - With count=0, assert re alone.
   - Required: underflow=1; count, pointers and dout are unchanged.
   - Then assert we&re with din=0x33.
   - Required: count=1 and dout is not updated.
   - Then pulse clr.
   - Required: count=0, underflow=0.
6. FWFT=1 (DATA_WIDTH=16, FIFO_DEPTH=4):
   - Write 0xBEEF.
   - Required: after that edge, empty=0 and dout=0xBEEF with no re.
   - Assert re.
   - Required: empty=1 next cycle.
   - Drop rst mid-burst.
   - Required: count=0 and flags return to their reset values on that edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with wrap-around pointers, occupancy count,
// programmable almost-full/empty thresholds, sticky error flags and optional FWFT output.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PNTR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PNTR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PNTR_WIDTH:0]   DEPTH_CNT = FIFO_DEPTH[PNTR_WIDTH:0];
  localparam logic [PNTR_WIDTH:0]   AF_CNT    = AF_LEVEL[PNTR_WIDTH:0];
  localparam logic [PNTR_WIDTH:0]   AE_CNT    = AE_LEVEL[PNTR_WIDTH:0];
  localparam logic [PNTR_WIDTH-1:0] PTR_ONE   = {{(PNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PNTR_WIDTH:0]   CNT_ONE   = {{PNTR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PNTR_WIDTH-1:0] w_ptr;
  logic [PNTR_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  rd_ok;
  logic                  wr_ok;

  // Flags are pure decodes of the registered count.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == {(PNTR_WIDTH+1){1'b0}});
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // In FWFT mode the head entry is presented directly; otherwise the read register drives dout.
  assign dout = (FWFT != 0) ? mem[r_ptr] : dout_reg;

  // Accept decisions from pre-edge state; a read frees room for a write into a full FIFO.
  always_comb begin
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (re && !empty) begin
      rd_ok = 1'b1;
    end else begin
      rd_ok = 1'b0;
    end
    if (we && (!full || rd_ok)) begin
      wr_ok = 1'b1;
    end else begin
      wr_ok = 1'b0;
    end
  end

  // All FIFO state: storage, pointers, count, read register and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr     <= {PNTR_WIDTH{1'b0}};
      r_ptr     <= {PNTR_WIDTH{1'b0}};
      count     <= {(PNTR_WIDTH+1){1'b0}};
      dout_reg  <= {DATA_WIDTH{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_ptr     <= {PNTR_WIDTH{1'b0}};
      r_ptr     <= {PNTR_WIDTH{1'b0}};
      count     <= {(PNTR_WIDTH+1){1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[w_ptr] <= din;
        w_ptr      <= w_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        r_ptr <= r_ptr + PTR_ONE;
        if (FWFT == 0) begin
          dout_reg <= mem[r_ptr];
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (we && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (re && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: standard-mode depth-8 FIFO plus an FWFT depth-4 16-bit FIFO.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Standard-mode instance (8 x 8)
  logic       rst, clr, we, re;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  // FWFT instance (4 x 16)
  logic        rst_f, clr_f, we_f, re_f;
  logic [15:0] din_f, dout_f;
  logic        full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [2:0]  count_f;

  sync_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .din(din), .re(re), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst_f), .clr(clr_f), .we(we_f), .din(din_f), .re(re_f), .dout(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
    .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change only here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
    rst_f = 1'b0; clr_f = 1'b0; we_f = 1'b0; re_f = 1'b0; din_f = 16'h0000;

    // 1. Reset and flags
    step(); step();
    rst = 1'b1; rst_f = 1'b1;
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);

    // 2. Fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; din = 8'(8'h10 + i);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf_pre", 32'(overflow), 32'd0);
    din = 8'hAA;
    step();
    we = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1;
      step();
      check("drain_dout", 32'(dout), 32'(8'h10 + i));
      check("drain_count", 32'(count), 32'(7 - i));
    end
    re = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_dout_hold", 32'(dout), 32'h17);

    // 3. Wrap-around with simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; din = 8'(8'h30 + i);
      step();
    end
    check("pre_count", 32'(count), 32'd5);
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; re = 1'b1; din = 8'(8'h40 + i);
      step();
      check("wrap_count", 32'(count), 32'd5);
      check("wrap_dout", 32'(dout), (i < 5) ? 32'(8'h30 + i) : 32'(8'h40 + i - 5));
    end
    we = 1'b0; re = 1'b0;

    // 4. Full with simultaneous read/write; contents now 4F..53, then 60..62
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; din = 8'(8'h60 + i);
      step();
    end
    check("full_pre", 32'(full), 32'd1);
    we = 1'b1; re = 1'b1; din = 8'h55;
    step();
    we = 1'b0; re = 1'b0;
    check("fullrw_count", 32'(count), 32'd8);
    check("fullrw_ovf", 32'(overflow), 32'd0);
    check("fullrw_dout", 32'(dout), 32'h4F);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1;
      step();
      case (i)
        0: check("tail_dout", 32'(dout), 32'h50);
        1: check("tail_dout", 32'(dout), 32'h51);
        2: check("tail_dout", 32'(dout), 32'h52);
        3: check("tail_dout", 32'(dout), 32'h53);
        4: check("tail_dout", 32'(dout), 32'h60);
        5: check("tail_dout", 32'(dout), 32'h61);
        6: check("tail_dout", 32'(dout), 32'h62);
        default: check("tail_dout_55", 32'(dout), 32'h55);
      endcase
    end
    re = 1'b0;
    check("tail_empty", 32'(empty), 32'd1);

    // 5. Empty boundary
    re = 1'b1;
    step();
    re = 1'b0;
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    check("unf_dout", 32'(dout), 32'h55);
    we = 1'b1; re = 1'b1; din = 8'h33;
    step();
    we = 1'b0; re = 1'b0;
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_dout", 32'(dout), 32'h55);
    check("emptyrw_unf", 32'(underflow), 32'd1);
    re = 1'b1;
    step();
    re = 1'b0;
    check("emptyrw_read", 32'(dout), 32'h33);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);

    // 6. FWFT instance
    we_f = 1'b1; din_f = 16'hBEEF;
    step();
    we_f = 1'b0;
    check("fwft_empty", 32'(empty_f), 32'd0);
    check("fwft_dout", 32'(dout_f), 32'h0000BEEF);
    check("fwft_count", 32'(count_f), 32'd1);
    re_f = 1'b1;
    step();
    re_f = 1'b0;
    check("fwft_pop_empty", 32'(empty_f), 32'd1);
    check("fwft_unf", 32'(underflow_f), 32'd0);
    we_f = 1'b1; din_f = 16'h1111;
    step();
    check("fwft_burst_dout", 32'(dout_f), 32'h00001111);
    din_f = 16'h2222;
    step();
    check("fwft_burst_af", 32'(almost_full_f), 32'd1);
    check("fwft_burst_dout2", 32'(dout_f), 32'h00001111);
    din_f = 16'h3333; rst_f = 1'b0;
    step();
    rst_f = 1'b1; we_f = 1'b0;
    check("fwft_rst_count", 32'(count_f), 32'd0);
    check("fwft_rst_empty", 32'(empty_f), 32'd1);
    check("fwft_rst_full", 32'(full_f), 32'd0);
    check("fwft_rst_ae", 32'(almost_empty_f), 32'd1);
    check("fwft_rst_af", 32'(almost_full_f), 32'd0);
    check("fwft_rst_ovf", 32'(overflow_f), 32'd0);
    check("fwft_rst_unf", 32'(underflow_f), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
